lte_up_dfe_trans_inf: RTL and testbench



---
 rtl/lte_up_dfe_trans_pkg.sv | 23 ++
 rtl/lte_up_dfe_trans_if.sv | 24 ++
 rtl/lte_up_iq_buf.sv | 25 ++
 rtl/lte_up_dfe_trans_inf.sv | 140 ++++++++++++++
 tb/tb_lte_up_dfe_trans_inf.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/lte_up_dfe_trans_pkg.sv
// Shared constants for the LTE uplink DFE transpose block: mode codes, group length, periods.
package lte_up_dfe_trans_pkg;

  localparam logic [1:0] MODE_20M_DFLT = 2'd0;
  localparam logic [1:0] MODE_10M      = 2'd1;
  localparam logic [1:0] MODE_15M      = 2'd2;
  localparam logic [1:0] MODE_20M      = 2'd3;

  localparam int unsigned IQ_LEN     = 8;
  localparam int unsigned PERIOD_10M = 32;
  localparam int unsigned PERIOD_20M = 16;

  typedef enum logic {StIdle, StLock} state_e;

  // Last phase of a group; 10M and 15M carry 16 padding samples per group.
  function automatic logic [4:0] last_phase(input logic [1:0] mode);
    if (mode == MODE_10M || mode == MODE_15M) begin
      return 5'(PERIOD_10M - 1);
    end
    return 5'(PERIOD_20M - 1);
  endfunction

endpackage

// File: rtl/lte_up_dfe_trans_if.sv
// Serial DFE input stream and parallel IQ output bundle of lte_up_dfe_trans_inf.
interface lte_up_dfe_trans_if #(
  parameter int unsigned DW = 16
);
  logic [1:0]      mod_sel;
  logic            fram;
  logic [DW-1:0]   data;
  logic            out_fram;
  logic            vld;
  logic            xant;
  logic [2*DW-1:0] out_data;
  logic            align_err;
  logic [15:0]     err_cnt;

  modport master (
    output mod_sel, fram, data,
    input  out_fram, vld, xant, out_data, align_err, err_cnt
  );

  modport slave (
    input  mod_sel, fram, data,
    output out_fram, vld, xant, out_data, align_err, err_cnt
  );
endinterface

// File: rtl/lte_up_iq_buf.sv
// Write-by-index holding buffer for the I samples of one group; contents are not reset.
module lte_up_iq_buf #(
  parameter int unsigned DW     = 16,
  parameter int unsigned IQ_LEN = 8,
  parameter int unsigned AW     = 3
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [IQ_LEN];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/lte_up_dfe_trans_inf.sv
// Converts the serial I-then-Q DFE stream into parallel {I,Q} words with frame alignment checks.
// Define LTE_UP_TRANS_ERR_CNT_EN to build the saturating alignment error counter.
module lte_up_dfe_trans_inf #(
  parameter int unsigned DW     = 16,
  parameter int unsigned IQ_LEN = lte_up_dfe_trans_pkg::IQ_LEN
) (
  input  logic            sys_clk_491p52,
  input  logic            sys_rst_491p52,
  input  logic [1:0]      i_mod_sel,
  input  logic            i_fram,
  input  logic [DW-1:0]   i_data,
  output logic            o_fram,
  output logic            o_vld,
  output logic            o_xant,
  output logic [2*DW-1:0] o_data,
  output logic            o_align_err,
  output logic [15:0]     o_err_cnt
);
  import lte_up_dfe_trans_pkg::*;

  localparam int unsigned AW = (IQ_LEN > 1) ? $clog2(IQ_LEN) : 1;

  state_e          state_q, state_d;
  logic [4:0]      phase_q, phase_d;
  logic [4:0]      last_q, last_d;
  logic            pend_q, pend_d;
  logic            fram_q, fram_d;
  logic            vld_q, vld_d;
  logic            xant_q, xant_d;
  logic            err_q, err_d;
  logic [2*DW-1:0] data_q, data_d;

  logic            in_i, in_q;
  logic            wr_en;
  logic [AW-1:0]   wr_idx, rd_idx;
  logic [DW-1:0]   rd_data;

  // phase_d is the phase of the sample on i_data this cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pend_d  = pend_q;
    if (i_fram) begin
      phase_d = '0;
      last_d  = last_phase(i_mod_sel);
      state_d = StLock;
    end else if (phase_q == last_q) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 5'd1;
    end

    in_i   = (phase_d < 5'(IQ_LEN));
    in_q   = !in_i && (phase_d < 5'(2 * IQ_LEN));
    wr_en  = in_i;
    wr_idx = AW'(phase_d);
    rd_idx = AW'(phase_d - 5'(IQ_LEN));

    vld_d  = in_q && (state_q == StLock);
    data_d = vld_d ? {rd_data, i_data} : data_q;
    xant_d = vld_d && (phase_d == 5'(2 * IQ_LEN - 1));
    fram_d = vld_d && pend_q;
    if (vld_d) begin
      pend_d = 1'b0;
    end
    if (i_fram) begin
      pend_d = 1'b1;
    end

    // A locked frame boundary must follow the last phase of the previous group.
    err_d = i_fram && (state_q == StLock) && (phase_q != last_q);
  end

  always_ff @(posedge sys_clk_491p52 or negedge sys_rst_491p52) begin
    if (!sys_rst_491p52) begin
      state_q <= StIdle;
      phase_q <= '0;
      last_q  <= 5'(PERIOD_20M - 1);
      pend_q  <= 1'b0;
      fram_q  <= 1'b0;
      vld_q   <= 1'b0;
      xant_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      fram_q  <= fram_d;
      vld_q   <= vld_d;
      xant_q  <= xant_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  lte_up_iq_buf #(
    .DW     (DW),
    .IQ_LEN (IQ_LEN),
    .AW     (AW)
  ) u_iq_buf (
    .clk_i     (sys_clk_491p52),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i (i_data),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

`ifdef LTE_UP_TRANS_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk_491p52 or negedge sys_rst_491p52) begin
    if (!sys_rst_491p52) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err_cnt = err_cnt_q;
`else
  assign o_err_cnt = '0;
`endif

  assign o_fram      = fram_q;
  assign o_vld       = vld_q;
  assign o_xant      = xant_q;
  assign o_data      = data_q;
  assign o_align_err = err_q;

endmodule

// File: tb/tb_lte_up_dfe_trans_inf.sv
// Randomised bench for lte_up_dfe_trans_inf against a frame-position reference model.
module tb_lte_up_dfe_trans_inf;
  localparam int unsigned DW = 16;

  logic clk;
  logic rst_n;

  lte_up_dfe_trans_if #(.DW(DW)) bus ();

  lte_up_dfe_trans_inf #(
    .DW     (DW),
    .IQ_LEN (8)
  ) dut (
    .sys_clk_491p52 (clk),
    .sys_rst_491p52 (rst_n),
    .i_mod_sel      (bus.mod_sel),
    .i_fram         (bus.fram),
    .i_data         (bus.data),
    .o_fram         (bus.out_fram),
    .o_vld          (bus.vld),
    .o_xant         (bus.xant),
    .o_data         (bus.out_data),
    .o_align_err    (bus.align_err),
    .o_err_cnt      (bus.err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: group position is (cycle - frame start) mod period.
  int unsigned cyc = 0;
  int unsigned m_t0;
  int unsigned m_per;
  bit          m_locked;
  bit          m_pend;
  logic [DW-1:0]   m_ibuf [8];
  logic [2*DW-1:0] m_last;
  int unsigned m_cnt;

  logic            e_vld, e_fram, e_xant, e_err;
  logic [2*DW-1:0] e_data;

  int n_vld, n_fram, n_xant, n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_pend   = 1'b0;
    m_last   = '0;
    m_cnt    = 0;
  endtask

  task automatic model_step(input logic fram, input logic [1:0] mod, input logic [DW-1:0] data);
    int unsigned p;
    e_vld  = 1'b0;
    e_fram = 1'b0;
    e_xant = 1'b0;
    e_err  = 1'b0;
    if (fram) begin
      if (m_locked && (((cyc - m_t0) % m_per) != 0)) e_err = 1'b1;
      m_locked = 1'b1;
      m_t0     = cyc;
      m_per    = (mod == 2'd1 || mod == 2'd2) ? 32 : 16;
      m_pend   = 1'b1;
    end
    if (m_locked) begin
      p = (cyc - m_t0) % m_per;
      if (p < 8) begin
        m_ibuf[p] = data;
      end else if (p < 16) begin
        e_vld  = 1'b1;
        e_data = {m_ibuf[p-8], data};
        e_xant = (p == 15);
        e_fram = m_pend;
        m_pend = 1'b0;
      end
    end
    if (e_vld) m_last = e_data;
    else e_data = m_last;
`ifdef LTE_UP_TRANS_ERR_CNT_EN
    if (e_err && m_cnt < 32'hFFFF) m_cnt++;
`endif
    cyc++;
  endtask

  task automatic clr_cnt();
    n_vld = 0; n_fram = 0; n_xant = 0; n_err = 0;
  endtask

  task automatic cycle(input logic fram, input logic [1:0] mod, input logic [DW-1:0] data);
    bus.fram    = fram;
    bus.mod_sel = mod;
    bus.data    = data;
    model_step(fram, mod, data);
    @(posedge clk);
    #1;
    check_eq("o_vld", 32'(bus.vld), 32'(e_vld));
    check_eq("o_fram", 32'(bus.out_fram), 32'(e_fram));
    check_eq("o_xant", 32'(bus.xant), 32'(e_xant));
    check_eq("o_align_err", 32'(bus.align_err), 32'(e_err));
    check_eq("o_data", bus.out_data, e_data);
    check_eq("o_err_cnt", 32'(bus.err_cnt), m_cnt);
    n_vld  += int'(bus.vld);
    n_fram += int'(bus.out_fram);
    n_xant += int'(bus.xant);
    n_err  += int'(bus.align_err);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_vld"}, 32'(bus.vld), 32'd0);
    check_eq({tag, "_fram"}, 32'(bus.out_fram), 32'd0);
    check_eq({tag, "_xant"}, 32'(bus.xant), 32'd0);
    check_eq({tag, "_err"}, 32'(bus.align_err), 32'd0);
    check_eq({tag, "_data"}, bus.out_data, 32'd0);
    check_eq({tag, "_cnt"}, 32'(bus.err_cnt), 32'd0);
  endtask

  initial begin
    logic [1:0]  mod;
    int unsigned per, len;

    rst_n       = 1'b0;
    bus.fram    = 1'b0;
    bus.mod_sel = 2'd0;
    bus.data    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Pre-lock: data with no frame pulse must produce nothing.
    clr_cnt();
    for (int i = 0; i < 40; i++) cycle(1'b0, 2'($urandom), 16'($urandom));
    check_eq("idle_vld_cnt", n_vld, 0);

    // 10M directed group.
    clr_cnt();
    for (int p = 0; p < 32; p++) begin
      cycle(p == 0, (p == 0) ? 2'd1 : 2'($urandom),
            (p < 8) ? 16'(p + 1) : (p < 16) ? 16'(101 + p - 8) : 16'd0);
      if (p == 8) check_eq("10m_first_word", bus.out_data, {16'd1, 16'd101});
      if (p == 15) check_eq("10m_last_word", bus.out_data, {16'd8, 16'd108});
    end
    check_eq("10m_vld_cnt", n_vld, 8);
    check_eq("10m_fram_cnt", n_fram, 1);
    check_eq("10m_xant_cnt", n_xant, 1);

    // 20M back-to-back groups.
    clr_cnt();
    for (int g = 0; g < 1000; g++) begin
      for (int p = 0; p < 16; p++) cycle(p == 0, 2'd3, 16'($urandom));
    end
    check_eq("20m_vld_cnt", n_vld, 8000);
    check_eq("20m_xant_cnt", n_xant, 1000);
    check_eq("20m_err_cnt", n_err, 0);

    // Frame reissued at phase 12, then a clean group.
    clr_cnt();
    for (int p = 0; p < 12; p++) cycle(p == 0, 2'd3, 16'($urandom));
    for (int p = 0; p < 16; p++) cycle(p == 0, 2'd3, 16'($urandom));
    check_eq("mis_err_cnt", n_err, 1);
    check_eq("mis_vld_cnt", n_vld, 12);
    check_eq("mis_xant_cnt", n_xant, 1);

    // Frame reissued during I phases restarts the buffer.
    clr_cnt();
    for (int p = 0; p < 5; p++) cycle(p == 0, 2'd3, 16'($urandom));
    for (int p = 0; p < 16; p++) cycle(p == 0, 2'd3, 16'($urandom));
    check_eq("rst_i_err_cnt", n_err, 1);
    check_eq("rst_i_vld_cnt", n_vld, 8);

    // Reset asserted at phase 10.
    for (int p = 0; p < 10; p++) cycle(p == 0, 2'd3, 16'($urandom));
    bus.fram = 1'b0;
    bus.data = 16'($urandom);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_edge");
    model_reset();
    cyc++;
    rst_n = 1'b1;
    clr_cnt();
    for (int i = 0; i < 20; i++) cycle(1'b0, 2'd3, 16'($urandom));
    check_eq("post_rst_vld_cnt", n_vld, 0);
    for (int p = 0; p < 16; p++) cycle(p == 0, 2'd3, 16'($urandom));
    check_eq("post_rst_group_vld", n_vld, 8);

    // Random modes, truncated frames, mode_sel noise between frames.
    for (int f = 0; f < 150; f++) begin
      mod = 2'($urandom_range(0, 3));
      per = (mod == 2'd1 || mod == 2'd2) ? 32 : 16;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, per - 1) : per;
      cycle(1'b1, mod, 16'($urandom));
      for (int i = 1; i < int'(len); i++) cycle(1'b0, 2'($urandom), 16'($urandom));
    end

`ifdef LTE_UP_TRANS_ERR_CNT_EN
    for (int i = 0; i < 65540; i++) cycle(1'b1, 2'd3, 16'($urandom));
    check_eq("err_cnt_sat", 32'(bus.err_cnt), 32'hFFFF);
`else
    for (int i = 0; i < 200; i++) cycle(1'b1, 2'd3, 16'($urandom));
    check_eq("err_cnt_off", 32'(bus.err_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
